// File: rtl/pc_stack_unit_if.sv
// rtl/pc_stack_unit_if.sv - control-side bundle for pc_stack_unit: op request in, pc/stack status out
interface pc_stack_unit_if #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 8
);
  localparam int DW = $clog2(STACK_DEPTH) + 1;

  logic             en;
  logic [2:0]       op;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [DW-1:0]    depth;
  logic             stack_full;
  logic             stack_empty;
  logic             stack_err;

  modport master (
    output en, op, target, offset,
    input  pc, pc_next, depth, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  en, op, target, offset,
    output pc, pc_next, depth, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter with INC/JUMP/BRANCH/CALL/RET and return-address stack
// Optional macro PC_STACK_GUARD_EN: suppress CALL-when-full / RET-when-empty and raise sticky stack_err.
module pc_stack_unit #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VEC   = '0,
  parameter int               STEP        = 1,
  parameter int               STACK_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  pc_stack_unit_if.slave bus
);
  localparam int               SPW    = $clog2(STACK_DEPTH);
  localparam int               DW     = SPW + 1;
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [DW-1:0]    FULL_D = DW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_INC    = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4
  } op_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];
  logic             push;
  logic             full, empty;
  logic [WIDTH-1:0] pc_inc;

  assign pc_inc = pc_q + STEP_W;
  assign full   = (depth_q == FULL_D);
  assign empty  = (depth_q == '0);

`ifdef PC_STACK_GUARD_EN
  logic err_q, err_d;
`endif

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    depth_d = depth_q;
    push    = 1'b0;
`ifdef PC_STACK_GUARD_EN
    err_d   = err_q;
`endif
    if (bus.en) begin
      case (bus.op)
        OP_INC:    pc_d = pc_inc;
        OP_JUMP:   pc_d = bus.target;
        OP_BRANCH: pc_d = pc_q + bus.offset;
        OP_CALL: begin
          if (full) begin
`ifdef PC_STACK_GUARD_EN
            err_d = 1'b1;
`else
            // Circular: sp already points at the oldest entry, so it gets overwritten.
            push = 1'b1;
            sp_d = sp_q + SPW'(1);
            pc_d = bus.target;
`endif
          end else begin
            push    = 1'b1;
            sp_d    = sp_q + SPW'(1);
            depth_d = depth_q + DW'(1);
            pc_d    = bus.target;
          end
        end
        OP_RET: begin
          if (empty) begin
`ifdef PC_STACK_GUARD_EN
            err_d = 1'b1;
`else
            pc_d = pc_inc;
`endif
          end else begin
            sp_d    = sp_q - SPW'(1);
            depth_d = depth_q - DW'(1);
            pc_d    = stack_q[sp_q - SPW'(1)];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_VEC;
      sp_q    <= '0;
      depth_q <= '0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      depth_q <= depth_d;
    end
  end

`ifdef PC_STACK_GUARD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign bus.stack_err = err_q;
`else
  assign bus.stack_err = 1'b0;
`endif

  // Stack storage needs no reset; depth gates every read.
  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q] <= pc_inc;
  end

  assign bus.pc          = pc_q;
  assign bus.pc_next     = pc_d;
  assign bus.depth       = depth_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - scoreboard bench for pc_stack_unit against a queue-based reference model
module tb_pc_stack_unit;
  localparam int W  = 16;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_stack_unit_if #(.WIDTH(W), .STACK_DEPTH(SD)) bus();

  pc_stack_unit #(
    .WIDTH(W), .RESET_VEC(16'h0000), .STEP(1), .STACK_DEPTH(SD)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [W-1:0] pc;
    logic [2:0]   depth;
    logic         err;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_stack[$];
  logic [W-1:0] m_pc;
  logic         m_err;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 16'h0000;
    m_err = 1'b0;
    m_stack.delete();
  endtask

  // One op per call; model result is queued for the monitor, pc_next checked here.
  task automatic issue(input logic en, input logic [2:0] op, input logic [W-1:0] tgt,
                       input logic [W-1:0] off);
    logic [W-1:0] npc;
    @(negedge clk);
    bus.en = en; bus.op = op; bus.target = tgt; bus.offset = off;
    npc = m_pc;
    if (en) begin
      case (op)
        3'd0: npc = m_pc + 16'd1;
        3'd1: npc = tgt;
        3'd2: npc = m_pc + off;
        3'd3: begin
          if (m_stack.size() == SD) begin
`ifdef PC_STACK_GUARD_EN
            m_err = 1'b1;
`else
            void'(m_stack.pop_front());
            m_stack.push_back(m_pc + 16'd1);
            npc = tgt;
`endif
          end else begin
            m_stack.push_back(m_pc + 16'd1);
            npc = tgt;
          end
        end
        3'd4: begin
          if (m_stack.size() == 0) begin
`ifdef PC_STACK_GUARD_EN
            m_err = 1'b1;
`else
            npc = m_pc + 16'd1;
`endif
          end else begin
            npc = m_stack.pop_back();
          end
        end
        default: ;
      endcase
    end
    #1 check("pc_next", {16'h0, bus.pc_next}, {16'h0, npc});
    m_pc = npc;
    exp_q.push_back('{npc, 3'(m_stack.size()), m_err});
    @(posedge clk);
    #2 bus.en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    drain();
    @(negedge clk);
    reset = 1'b1;
    bus.en = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc",    bus.pc, e.pc);
        check("depth", bus.depth, e.depth);
        check("err",   bus.stack_err, e.err);
        check("full",  bus.stack_full, e.depth == 3'(SD));
        check("empty", bus.stack_empty, e.depth == 3'd0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.en = 1'b0; bus.op = 3'd0; bus.target = '0; bus.offset = '0;
    model_reset();
    #1;
    check("rst_pc",    bus.pc, 16'h0000);
    check("rst_depth", bus.depth, 0);
    check("rst_empty", bus.stack_empty, 1);
    check("rst_full",  bus.stack_full, 0);
    check("rst_err",   bus.stack_err, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) issue(1'b1, 3'd0, '0, '0);
    issue(1'b0, 3'd0, '0, '0);
    issue(1'b0, 3'd1, 16'h5555, '0);
    drain();
    check("t1_pc", bus.pc, 16'h0003);

    issue(1'b1, 3'd1, 16'h0010, '0);
    issue(1'b1, 3'd2, '0, 16'hFFFE);
    drain();
    check("t2_branch", bus.pc, 16'h000E);
    issue(1'b1, 3'd1, 16'hFFFF, '0);
    issue(1'b1, 3'd0, '0, '0);
    drain();
    check("t2_wrap", bus.pc, 16'h0000);
    issue(1'b1, 3'd1, 16'h1234, '0);
    drain();
    check("t2_jump", bus.pc, 16'h1234);

    issue(1'b1, 3'd1, 16'h0100, '0);
    issue(1'b1, 3'd3, 16'h0200, '0);
    issue(1'b1, 3'd3, 16'h0300, '0);
    issue(1'b1, 3'd4, '0, '0);
    drain();
    check("t3_ret1", bus.pc, 16'h0201);
    issue(1'b1, 3'd4, '0, '0);
    drain();
    check("t3_ret2", bus.pc, 16'h0101);
    check("t3_empty", bus.stack_empty, 1);

    issue(1'b1, 3'd1, 16'h0000, '0);
    for (int i = 1; i <= 5; i++) issue(1'b1, 3'd3, 16'(i * 16), '0);
    drain();
`ifdef PC_STACK_GUARD_EN
    check("t4_pc",  bus.pc, 16'h0040);
    check("t4_err", bus.stack_err, 1);
`else
    check("t4_pc",    bus.pc, 16'h0050);
    check("t4_depth", bus.depth, 4);
    for (int i = 4; i >= 1; i--) begin
      issue(1'b1, 3'd4, '0, '0);
      drain();
      check("t4_ret", bus.pc, 16'(i * 16 + 1));
    end
`endif

    do_reset();
    issue(1'b1, 3'd1, 16'h0007, '0);
    issue(1'b1, 3'd4, '0, '0);
    drain();
`ifdef PC_STACK_GUARD_EN
    check("t5_pc",  bus.pc, 16'h0007);
    check("t5_err", bus.stack_err, 1);
`else
    check("t5_pc", bus.pc, 16'h0008);
`endif

    for (int i = 0; i < 3; i++) issue(1'b1, 3'd3, 16'h0A00 + 16'(i), '0);
    drain();
    check("t6_pre_depth", bus.depth, 3);
    @(negedge clk);
    #2;
    reset = 1'b1;
    bus.en = 1'b1; bus.op = 3'd0;
    #1;
    check("t6_pc",      bus.pc, 16'h0000);
    check("t6_depth",   bus.depth, 0);
    check("t6_err",     bus.stack_err, 0);
    check("t6_empty",   bus.stack_empty, 1);
    check("t6_pc_next", bus.pc_next, 16'h0001);
    model_reset();
    @(negedge clk);
    bus.en = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      issue(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
            16'($urandom), 16'($urandom));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
